timer_multi_mem: RTL and testbench
==================================

Name: timer_multi_mem

Overview:
- Parametrised multi-channel timer with an integrated byte-enable bus register file.
- Each channel has its own prescaler, auto-reload counter, one-shot/periodic mode, event counter, sticky event flag and interrupt line.
- Sits on the peripheral bus and uses the same write/be/addr/data bus signalling as the existing single-channel timer memory.
- Replaces the split "timer core + timer_mem" pair with one self-contained block for N channels.

Parameters:
- NCH, 4, number of timer channels (1..8).
- CNT_W, 32, width of PRE, ARE, CNT and EVN registers (8..32); unused upper bits read 0 and ignore writes.
- BASE_W, 8, number of addr_bus bits decoded; the upper bits are ignored by this block.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- write_bus  in  1  bus write strobe; single cycle per access.
- be_bus  in  4  byte enables, lane i = data bits [8i+7:8i].
- addr_bus  in  32  byte address, word aligned; bits [1:0] are ignored.
- data_i_bus  in  32  write data.
- data_o_bus  out  32  read data; combinational from addr_bus/be_bus; disabled lanes read 0.
- irq_o  out  NCH  per-channel level interrupt.

Behaviour:
- Reset: all registers, prescaler counters, data-path flags and irq_o are 0. Reset is asserted asynchronously and released synchronously to clk_i.
- Address decode: channel = addr_bus[BASE_W-1:5], offset = addr_bus[4:2]. Channel >= NCH or an unmapped offset: reads 0, writes ignored.
- Per-channel register map (word offsets):
  - 0 PRE: prescaler divide value.
  - 1 ARE: auto-reload compare value.
  - 2 CTRL: bit0 ENA, bit1 MOD (1 = periodic, 0 = one-shot), bit2 CLR (write-1 strobe, always reads 0).
  - 3 CNT: current count, RW.
  - 4 EVN: number of events, RW.
  - 5 STAT: bit0 EVC sticky event flag, write-1-to-clear.
  - 6 IEN: bit0 interrupt enable.
- Byte writes: a byte is updated only when write_bus=1 and its be_bus lane is set.
- Prescaler: when ENA=1, the internal pcnt increments each cycle. When pcnt==PRE, a tick is generated and pcnt returns to 0. PRE=0 gives a tick every cycle.
- On a tick:
  - If CNT != ARE: CNT <= CNT+1.
  - If CNT == ARE (event): CNT <= 0, EVN <= EVN+1 (wraps modulo 2^CNT_W), EVC <= 1. If MOD=0, ENA <= 0 in the same edge.
  - ARE=0 with PRE=0 gives an event every cycle.
- ENA=0: pcnt, CNT and EVN hold; EVC holds.
- CLR write: CNT, pcnt, EVN and EVC are all set to 0 on that edge. ENA and MOD take their written values in the same write.
- Simultaneous bus write and hardware update of the same byte: the bus write wins for the written bytes. Unwritten bytes take the hardware update; a CNT write suppresses that cycle's tick for that channel.
- EVC W1C collision with a new event in the same cycle: the set wins, so EVC stays 1.
- Latency: ENA write at edge k → first tick at edge k+1+PRE.
- Channels are fully independent; no cross-channel interaction.

Optional Feature:
- Macro: TIMER_MULTI_IRQ_EN.
- Defined: irq_o[c] = EVC[c] & IEN[c], registered, i.e. asserted the cycle after EVC sets; IEN is RW.
- Undefined: irq_o is tied to 0, the IEN register is absent (reads 0, writes ignored) and its flops are not instantiated.

Test Plan:
- Reset: pulse rst_ni low mid-count with ch0 ENA=1, CNT=5 → CNT, EVN, EVC and irq_o go to 0 immediately, without waiting for a clock edge.
- Periodic, ch1: PRE=1, ARE=3, MOD=1, ENA=1 → an event every 8 cycles; after 24 cycles EVN=3, EVC=1; CNT sequence 0,0,1,1,2,2,3,3,0.
- One-shot, ch2: PRE=0, ARE=2, MOD=0 → event on the 3rd tick, then ENA reads 0 and CNT stays 0; EVN=1.
- Byte-lane write: write 0xAABBCCDD to ch0 ARE with be=0b0101 → ARE=0x00BB00DD; read of ch0 ARE with be=0b0011 returns 0x000000DD.
- Collisions: W1C to STAT in the same cycle as an event → EVC remains 1. Write CNT=0x10 during an active tick → CNT=0x10 exactly.
- IRQ (macro defined): ch3 IEN=1, event occurs → irq_o[3]=1 one cycle after EVC. W1C of STAT → irq_o[3]=0 next cycle. Access to channel index 5 with NCH=4 → reads 0, no register changes.

Source files
------------

// File: rtl/timer_multi_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi_mem_if
// Brief    : Peripheral bus bundle (write strobe, byte enables, address, data).
// Revision : 1.0 - initial release
// ============================================================================
interface timer_multi_mem_if;
  logic        write_bus;
  logic [3:0]  be_bus;
  logic [31:0] addr_bus;
  logic [31:0] data_i_bus;
  logic [31:0] data_o_bus;

  modport master (
    output write_bus, be_bus, addr_bus, data_i_bus,
    input  data_o_bus
  );

  modport slave (
    input  write_bus, be_bus, addr_bus, data_i_bus,
    output data_o_bus
  );
endinterface
`default_nettype wire

// File: rtl/timer_multi_mem.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi_mem
// Brief    : NCH-channel prescaled auto-reload timer with byte-enable register
//            file; optional interrupt logic enabled by TIMER_MULTI_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module timer_multi_mem #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 32,
  parameter int BASE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  timer_multi_mem_if.slave bus,
  output logic [NCH-1:0]   irq_o
);

  localparam int C_CH_W = BASE_W - 5;

  logic [C_CH_W-1:0] w_ch;
  logic [2:0]        w_off;
  logic [31:0]       w_mask;
  logic [31:0]       w_ch_rd [NCH];
  logic [31:0]       w_rdata;
  logic              w_unused_addr;

  assign w_ch   = bus.addr_bus[BASE_W-1:5];
  assign w_off  = bus.addr_bus[4:2];
  assign w_mask = {{8{bus.be_bus[3]}}, {8{bus.be_bus[2]}},
                   {8{bus.be_bus[1]}}, {8{bus.be_bus[0]}}};
  assign w_unused_addr = ^{bus.addr_bus[31:BASE_W], bus.addr_bus[1:0]};

  function automatic logic [CNT_W-1:0] merge(input logic [CNT_W-1:0] old_val,
                                             input logic [31:0]      wdata,
                                             input logic [31:0]      mask);
    logic [31:0] o32;
    o32 = 32'(old_val);
    return CNT_W'((o32 & ~mask) | (wdata & mask));
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [CNT_W-1:0] r_pre, r_are, r_cnt, r_evn, r_pcnt;
    logic             r_ena, r_mod, r_evc;
    logic             w_sel, w_wr_pre, w_wr_are, w_wr_cnt, w_wr_evn;
    logic             w_ctrl_wr, w_clr, w_w1c, w_pmatch, w_tick, w_event;
    logic [CNT_W-1:0] w_pcnt_hw, w_cnt_hw, w_evn_hw;
    logic [31:0]      w_rd;

    assign w_sel     = bus.write_bus && (w_ch == C_CH_W'(c));
    assign w_wr_pre  = w_sel && (w_off == 3'd0);
    assign w_wr_are  = w_sel && (w_off == 3'd1);
    assign w_ctrl_wr = w_sel && (w_off == 3'd2) && bus.be_bus[0];
    assign w_wr_cnt  = w_sel && (w_off == 3'd3) && (|bus.be_bus);
    assign w_wr_evn  = w_sel && (w_off == 3'd4);
    assign w_w1c     = w_sel && (w_off == 3'd5) && bus.be_bus[0] && bus.data_i_bus[0];
    assign w_clr     = w_ctrl_wr && bus.data_i_bus[2];

    // A CNT write owns the counter for that cycle, so the tick is dropped.
    assign w_pmatch  = (r_pcnt == r_pre);
    assign w_tick    = r_ena && w_pmatch && !w_wr_cnt;
    assign w_event   = w_tick && (r_cnt == r_are);
    assign w_pcnt_hw = !r_ena ? r_pcnt : (w_pmatch ? '0 : r_pcnt + CNT_W'(1));
    assign w_cnt_hw  = w_event ? '0 : (w_tick ? r_cnt + CNT_W'(1) : r_cnt);
    assign w_evn_hw  = w_event ? r_evn + CNT_W'(1) : r_evn;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pre  <= '0;
        r_are  <= '0;
        r_cnt  <= '0;
        r_evn  <= '0;
        r_pcnt <= '0;
        r_ena  <= 1'b0;
        r_mod  <= 1'b0;
        r_evc  <= 1'b0;
      end else begin
        if (w_wr_pre) r_pre <= merge(r_pre, bus.data_i_bus, w_mask);
        if (w_wr_are) r_are <= merge(r_are, bus.data_i_bus, w_mask);
        if (w_clr) begin
          r_pcnt <= '0;
          r_cnt  <= '0;
          r_evn  <= '0;
          r_evc  <= 1'b0;
        end else begin
          r_pcnt <= w_pcnt_hw;
          r_cnt  <= w_wr_cnt ? merge(w_cnt_hw, bus.data_i_bus, w_mask) : w_cnt_hw;
          r_evn  <= w_wr_evn ? merge(w_evn_hw, bus.data_i_bus, w_mask) : w_evn_hw;
          r_evc  <= (r_evc & ~w_w1c) | w_event;
        end
        if (w_ctrl_wr) begin
          r_ena <= bus.data_i_bus[0];
          r_mod <= bus.data_i_bus[1];
        end else if (w_event && !r_mod) begin
          r_ena <= 1'b0;
        end
      end
    end

`ifdef TIMER_MULTI_IRQ_EN
    logic r_ien, r_irq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_ien <= 1'b0;
        r_irq <= 1'b0;
      end else begin
        if (w_sel && (w_off == 3'd6) && bus.be_bus[0]) r_ien <= bus.data_i_bus[0];
        r_irq <= r_evc & r_ien;
      end
    end

    assign irq_o[c] = r_irq;
`else
    assign irq_o[c] = 1'b0;
`endif

    always_comb begin
      w_rd = '0;
      case (w_off)
        3'd0: w_rd = 32'(r_pre);
        3'd1: w_rd = 32'(r_are);
        3'd2: w_rd = {30'd0, r_mod, r_ena};
        3'd3: w_rd = 32'(r_cnt);
        3'd4: w_rd = 32'(r_evn);
        3'd5: w_rd = {31'd0, r_evc};
`ifdef TIMER_MULTI_IRQ_EN
        3'd6: w_rd = {31'd0, r_ien};
`endif
        default: w_rd = '0;
      endcase
    end

    assign w_ch_rd[c] = w_rd;
  end

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_ch == C_CH_W'(c)) w_rdata = w_ch_rd[c];
    end
  end

  assign bus.data_o_bus = w_rdata & w_mask;

endmodule
`default_nettype wire

// File: tb/tb_timer_multi_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_multi_mem
// Brief    : Directed self-checking bench for timer_multi_mem (NCH=4, CNT_W=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_multi_mem;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] irq_o;
  logic [31:0] rdv;
  int checks = 0;
  int errors = 0;

  timer_multi_mem_if bus_if ();

  timer_multi_mem #(.NCH(4), .CNT_W(32), .BASE_W(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_if),
    .irq_o  (irq_o)
  );

  always #50 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a write captured by the next rising edge; return at the following falling edge.
  task automatic wr(input int ch, input int off, input logic [31:0] d, input logic [3:0] be);
    bus_if.write_bus  = 1'b1;
    bus_if.addr_bus   = 32'(ch * 32 + off * 4);
    bus_if.be_bus     = be;
    bus_if.data_i_bus = d;
    @(negedge clk_i);
    bus_if.write_bus  = 1'b0;
  endtask

  task automatic rd(input int ch, input int off, input logic [3:0] be, output logic [31:0] d);
    bus_if.addr_bus = 32'(ch * 32 + off * 4);
    bus_if.be_bus   = be;
    #1;
    d = bus_if.data_o_bus;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    bus_if.write_bus  = 1'b0;
    bus_if.be_bus     = 4'h0;
    bus_if.addr_bus   = '0;
    bus_if.data_i_bus = '0;

    step(2);
    rst_ni = 1'b1;
    rd(0, 3, 4'hF, rdv); check("rst_cnt0", rdv, 32'd0);
    rd(1, 0, 4'hF, rdv); check("rst_pre1", rdv, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);

    // Asynchronous reset in the middle of counting
    wr(0, 1, 32'd100, 4'hF);
    wr(0, 2, 32'd1, 4'hF);
    step(5);
    rd(0, 3, 4'hF, rdv); check("ch0_cnt_run", rdv, 32'd5);
    rst_ni = 1'b0;
    rd(0, 3, 4'hF, rdv); check("arst_cnt", rdv, 32'd0);
    rd(0, 4, 4'hF, rdv); check("arst_evn", rdv, 32'd0);
    rd(0, 5, 4'hF, rdv); check("arst_stat", rdv, 32'd0);
    rd(0, 2, 4'hF, rdv); check("arst_ctrl", rdv, 32'd0);
    rd(0, 1, 4'hF, rdv); check("arst_are", rdv, 32'd0);
    check("arst_irq", 32'(irq_o), 32'd0);
    step(1);
    rst_ni = 1'b1;

    // Periodic channel 1: PRE=1, ARE=3
    wr(1, 0, 32'd1, 4'hF);
    wr(1, 1, 32'd3, 4'hF);
    wr(1, 2, 32'd3, 4'hF);
    for (int i = 0; i < 9; i++) begin
      rd(1, 3, 4'hF, rdv); check($sformatf("ch1_cnt_seq%0d", i), rdv, 32'(seq[i]));
      step(1);
    end
    rd(1, 4, 4'hF, rdv); check("ch1_evn_1", rdv, 32'd1);
    step(15);
    rd(1, 4, 4'hF, rdv); check("ch1_evn_3", rdv, 32'd3);
    rd(1, 5, 4'hF, rdv); check("ch1_evc", rdv, 32'd1);
    rd(1, 3, 4'hF, rdv); check("ch1_cnt_wrap", rdv, 32'd0);

    // One-shot channel 2: PRE=0, ARE=2
    wr(2, 1, 32'd2, 4'hF);
    wr(2, 2, 32'd1, 4'hF);
    step(2);
    rd(2, 3, 4'hF, rdv); check("ch2_cnt_2", rdv, 32'd2);
    rd(2, 2, 4'hF, rdv); check("ch2_ena_on", rdv, 32'd1);
    step(1);
    rd(2, 3, 4'hF, rdv); check("ch2_cnt_evt", rdv, 32'd0);
    rd(2, 2, 4'hF, rdv); check("ch2_ena_off", rdv, 32'd0);
    step(3);
    rd(2, 3, 4'hF, rdv); check("ch2_cnt_hold", rdv, 32'd0);
    rd(2, 4, 4'hF, rdv); check("ch2_evn", rdv, 32'd1);
    rd(2, 5, 4'hF, rdv); check("ch2_evc", rdv, 32'd1);

    // Byte-lane write and masked read
    wr(0, 1, 32'hAABBCCDD, 4'b0101);
    rd(0, 1, 4'hF, rdv);    check("ch0_are_bytes", rdv, 32'h00BB00DD);
    rd(0, 1, 4'b0011, rdv); check("ch0_are_rdmask", rdv, 32'h000000DD);

    // W1C racing an event on channel 2 (event every cycle), then CLR
    wr(2, 1, 32'd0, 4'hF);
    wr(2, 2, 32'd3, 4'hF);
    wr(2, 5, 32'd1, 4'hF);
    rd(2, 5, 4'hF, rdv); check("w1c_vs_event", rdv, 32'd1);
    rd(2, 4, 4'hF, rdv); check("ch2_evn_2", rdv, 32'd2);
    wr(2, 2, 32'd4, 4'hF);
    rd(2, 4, 4'hF, rdv); check("clr_evn", rdv, 32'd0);
    rd(2, 5, 4'hF, rdv); check("clr_evc", rdv, 32'd0);
    rd(2, 2, 4'hF, rdv); check("clr_ctrl", rdv, 32'd0);
    rd(2, 3, 4'hF, rdv); check("clr_cnt", rdv, 32'd0);

    // CNT write during an active tick on channel 0
    wr(0, 2, 32'd3, 4'hF);
    wr(0, 3, 32'h10, 4'hF);
    rd(0, 3, 4'hF, rdv); check("cnt_wr_tick", rdv, 32'h10);
    step(1);
    rd(0, 3, 4'hF, rdv); check("cnt_after_wr", rdv, 32'h11);
    wr(0, 3, 32'h55, 4'b0001);
    rd(0, 3, 4'hF, rdv); check("cnt_byte_wr", rdv, 32'h55);
    wr(0, 2, 32'd7, 4'hF);
    rd(0, 2, 4'hF, rdv); check("ctrl_clr_rd0", rdv, 32'd3);
    rd(0, 3, 4'hF, rdv); check("ctrl_clr_cnt", rdv, 32'd0);
    step(1);
    rd(0, 3, 4'hF, rdv); check("ctrl_clr_run", rdv, 32'd1);
    wr(0, 2, 32'd0, 4'hF);

    // Out-of-range channel and unmapped offset
    wr(5, 0, 32'hFFFFFFFF, 4'hF);
    wr(5, 1, 32'hFFFFFFFF, 4'hF);
    rd(5, 0, 4'hF, rdv); check("ch5_rd", rdv, 32'd0);
    rd(1, 0, 4'hF, rdv); check("ch1_pre_keep", rdv, 32'd1);
    rd(1, 1, 4'hF, rdv); check("ch1_are_keep", rdv, 32'd3);
    rd(0, 7, 4'hF, rdv); check("unmapped_off", rdv, 32'd0);

    // Interrupt path on channel 3 (one-shot, event on first tick)
    wr(3, 6, 32'd1, 4'hF);
    wr(3, 2, 32'd1, 4'hF);
    check("irq_pre", 32'(irq_o), 32'd0);
    step(1);
    rd(3, 5, 4'hF, rdv); check("ch3_evc", rdv, 32'd1);
    check("irq_lag", 32'(irq_o), 32'd0);
    step(1);
`ifdef TIMER_MULTI_IRQ_EN
    check("irq_set", 32'(irq_o), 32'h8);
    rd(3, 6, 4'hF, rdv); check("ien_rd", rdv, 32'd1);
    wr(3, 5, 32'd1, 4'hF);
    check("irq_hold", 32'(irq_o), 32'h8);
    rd(3, 5, 4'hF, rdv); check("ch3_w1c", rdv, 32'd0);
    step(1);
    check("irq_clr", 32'(irq_o), 32'd0);
`else
    check("irq_tied", 32'(irq_o), 32'd0);
    rd(3, 6, 4'hF, rdv); check("ien_absent", rdv, 32'd0);
    wr(3, 5, 32'd1, 4'hF);
    rd(3, 5, 4'hF, rdv); check("ch3_w1c", rdv, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
